ddr_burst_wr_ctrl: RTL and testbench

- Downstream consumer of the 16-in/64-out asynchronous pixel FIFO, on the FIFO read-clock side.
- Monitors the FIFO read water level. Once a full burst is buffered, it issues one AXI4-style write burst of BURST_LEN 64-bit beats to the DDR frame buffer.
- Maintains a wrapping frame write address and reports frame completion.

---
 rtl/ddr_burst_wr_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ddr_burst_wr_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_wr_ctrl.sv
// Drains buffered pixel words from the async FIFO read side into fixed-length
// DDR write bursts, tracking a wrapping frame offset and flagging frame completion.
//
// state  | meaning
// IDLE   | wait for a full burst in the FIFO; apply a latched frame_start
// ADDR   | present burst start address until accepted
// DATA   | stream BURST_LEN beats through the 2-entry skid buffer
// RESP   | accept the write response, advance/wrap the frame offset
module ddr_burst_wr_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 28,
    parameter int LEVEL_WIDTH = 11,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_BEATS = 196608,
    parameter int BASE_ADDR   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    input  logic                   frame_start,
    output logic [ADDR_WIDTH-1:0]  m_awaddr,
    output logic [7:0]             m_awlen,
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [DATA_WIDTH-1:0]  m_wdata,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    output logic                   m_wlast,
    input  logic                   m_bvalid,
    output logic                   m_bready,
    output logic                   busy,
    output logic                   frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0]  BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0]  BURST_ADV  = ADDR_WIDTH'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0]  FRAME_END  = ADDR_WIDTH'(FRAME_BEATS);
    localparam logic [ADDR_WIDTH-1:0]  BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [8:0]             BL9        = 9'(BURST_LEN);
    localparam logic [LEVEL_WIDTH-1:0] BL_LEVEL   = LEVEL_WIDTH'(BURST_LEN);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   beat_offset_q, beat_offset_d;
    logic                    fs_pend_q, fs_pend_d;
    logic                    frame_done_q, frame_done_d;
    logic [8:0]              reads_q, reads_d;
    logic [8:0]              sent_q, sent_d;
    logic                    inflight_q;
    logic [1:0]              occ_q;
    logic [DATA_WIDTH-1:0]   buf0_q, buf1_q;
    logic                    push, pop, rd_en;

    assign m_wvalid = (occ_q != 2'd0);
    assign m_wdata  = buf0_q;
    assign m_wlast  = m_wvalid && (sent_q == BL9 - 9'd1);
    assign pop      = m_wvalid && m_wready;
    assign push     = inflight_q;

    // A beat leaving this cycle frees its slot, which keeps reads back-to-back
    // and sustains one beat per cycle while m_wready stays high.
    assign rd_en = (state_q == S_DATA)
                && ((3'(occ_q) + 3'(inflight_q) - 3'(pop)) < 3'd2)
                && (reads_q < BL9)
                && !fifo_rd_empty;

    assign fifo_rd_en = rd_en;
    assign m_awaddr   = BASE + beat_offset_q * BEAT_BYTES;
    assign m_awlen    = 8'(BURST_LEN - 1);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;

    always_comb begin
        state_d       = state_q;
        beat_offset_d = beat_offset_q;
        fs_pend_d     = fs_pend_q | frame_start;
        frame_done_d  = 1'b0;
        reads_d       = reads_q + {8'd0, rd_en};
        sent_d        = sent_q + {8'd0, pop};
        m_awvalid     = 1'b0;
        m_bready      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fs_pend_q) begin
                    beat_offset_d = '0;
                    fs_pend_d     = frame_start;
                end else if (fifo_rd_water_level >= BL_LEVEL && !fifo_rd_empty) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                m_awvalid = 1'b1;
                if (m_awready) begin
                    state_d = S_DATA;
                    reads_d = '0;
                    sent_d  = '0;
                end
            end
            S_DATA: begin
                if (pop && m_wlast) state_d = S_RESP;
            end
            S_RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    state_d = S_IDLE;
                    if (beat_offset_q + BURST_ADV == FRAME_END) begin
                        beat_offset_d = '0;
                        frame_done_d  = 1'b1;
                    end else begin
                        beat_offset_d = beat_offset_q + BURST_ADV;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            beat_offset_q <= '0;
            fs_pend_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            reads_q       <= '0;
            sent_q        <= '0;
            inflight_q    <= 1'b0;
            occ_q         <= 2'd0;
            buf0_q        <= '0;
            buf1_q        <= '0;
        end else begin
            state_q       <= state_d;
            beat_offset_q <= beat_offset_d;
            fs_pend_q     <= fs_pend_d;
            frame_done_q  <= frame_done_d;
            reads_q       <= reads_d;
            sent_q        <= sent_d;
            inflight_q    <= rd_en;
            // Head entry always drives m_wdata; entry 1 only fills behind it.
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) buf0_q <= fifo_rd_data;
                    else               buf1_q <= fifo_rd_data;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    buf0_q <= buf1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf0_q <= fifo_rd_data;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= fifo_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_burst_wr_ctrl.sv
// Bench for ddr_burst_wr_ctrl: FIFO/DDR models around the DUT, expected bursts
// queued at stimulus time and checked by an independent monitor.
module tb_ddr_burst_wr_ctrl;

    localparam int BL   = 16;
    localparam int FB   = 64;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_rd_en;
    logic [63:0] fifo_rd_data;
    logic        fifo_rd_empty;
    logic [10:0] fifo_rd_water_level;
    logic        frame_start;
    logic [27:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic        m_awvalid, m_awready;
    logic [63:0] m_wdata;
    logic        m_wvalid, m_wready, m_wlast;
    logic        m_bvalid, m_bready;
    logic        busy, frame_done;

    ddr_burst_wr_ctrl #(
        .DATA_WIDTH(64), .ADDR_WIDTH(28), .LEVEL_WIDTH(11),
        .BURST_LEN(BL), .FRAME_BEATS(FB), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty), .fifo_rd_water_level(fifo_rd_water_level),
        .frame_start(frame_start),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] fifo_q[$];
    logic [63:0] exp_data[$];
    logic [27:0] exp_addr[$];
    bit          exp_fd[$];

    int  model_off = 0;
    int  aw_pct = 100, w_pct = 100, b_pct = 100;
    bit  b_manual = 0, b_force = 0;
    bit  fs_req = 0;
    bit  rd_pend = 0;
    bit  full_rate = 0;

    int  bursts_done = 0;
    int  mon_beats = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: inputs change at the falling edge, DUT outputs sampled 1 ns later.
    task automatic step();
        @(negedge clk);
        if (rd_pend && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
        rd_pend = 0;
        fifo_rd_water_level = 11'(fifo_q.size());
        fifo_rd_empty       = (fifo_q.size() == 0);
        m_awready = ($urandom_range(99, 0) < aw_pct);
        m_wready  = ($urandom_range(99, 0) < w_pct);
        m_bvalid  = b_manual ? b_force : ($urandom_range(99, 0) < b_pct);
        frame_start = fs_req;
        fs_req = 0;
        #1;
        rd_pend = fifo_rd_en;
    endtask

    task automatic feed_words(input int n, input bit pattern);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            w = pattern ? {56'hC0FFEE_0000_0000, 8'(15 - i)} : {$urandom, $urandom};
            fifo_q.push_back(w);
            exp_data.push_back(w);
        end
    endtask

    // Reference: burst k of a frame starts at BASE + k*BL beats, wrapping at FB beats.
    task automatic expect_burst();
        exp_addr.push_back(28'(BASE + model_off * 8));
        exp_fd.push_back((model_off + BL) == FB);
        model_off = (model_off + BL) % FB;
    endtask

    task automatic pulse_fs();
        fs_req = 1;
        step();
        step();
        model_off = 0;
    endtask

    task automatic wait_done(input int start);
        int n;
        n = 0;
        while (bursts_done <= start && n < 3000) begin
            step();
            n++;
        end
        if (bursts_done <= start) chk(0, "burst_timeout", 64'(bursts_done), 64'(start + 1));
    endtask

    task automatic burst(input bit pattern);
        int start;
        start = bursts_done;
        feed_words(BL, pattern);
        expect_burst();
        wait_done(start);
    endtask

    task automatic check_idle_outputs();
        chk(fifo_rd_en == 0, "rst_rd_en", 64'(fifo_rd_en), 0);
        chk(m_awvalid == 0, "rst_awvalid", 64'(m_awvalid), 0);
        chk(m_wvalid == 0, "rst_wvalid", 64'(m_wvalid), 0);
        chk(m_wlast == 0, "rst_wlast", 64'(m_wlast), 0);
        chk(m_bready == 0, "rst_bready", 64'(m_bready), 0);
        chk(busy == 0, "rst_busy", 64'(busy), 0);
        chk(frame_done == 0, "rst_frame_done", 64'(frame_done), 0);
        chk(m_wdata == 64'd0, "rst_wdata", m_wdata, 0);
        chk(m_awaddr == 28'(BASE), "rst_awaddr", 64'(m_awaddr), 64'(BASE));
        chk(m_awlen == 8'(BL - 1), "rst_awlen", 64'(m_awlen), 64'(BL - 1));
    endtask

    // Monitor / scoreboard
    bit          fd_next = 0, busy_low = 0;
    bit          prev_aw_stall = 0, prev_w_stall = 0;
    logic [27:0] prev_awaddr;
    logic [63:0] prev_wdata;
    int          mon_reads = 0, mcyc = 0, first_cyc = 0;

    always @(negedge clk) begin
        logic [27:0] ea;
        logic [63:0] ed;
        #2;
        mcyc++;
        if (rst) begin
            fd_next = 0; busy_low = 0; prev_aw_stall = 0; prev_w_stall = 0;
            mon_beats = 0; mon_reads = 0;
        end else begin
            chk(frame_done == fd_next, "frame_done", 64'(frame_done), 64'(fd_next));
            if (busy_low) chk(busy == 0, "busy_fall", 64'(busy), 0);
            fd_next = 0;
            busy_low = 0;
            if (prev_aw_stall)
                chk(m_awvalid && m_awaddr == prev_awaddr, "aw_hold", 64'(m_awaddr), 64'(prev_awaddr));
            if (prev_w_stall)
                chk(m_wvalid && m_wdata == prev_wdata, "w_hold", m_wdata, prev_wdata);
            if (fifo_rd_en) begin
                chk(!fifo_rd_empty, "rd_when_empty", 64'(fifo_rd_empty), 0);
                mon_reads++;
            end
            if (m_awvalid && m_awready) begin
                if (exp_addr.size() == 0) begin
                    chk(0, "aw_unexpected", 64'(m_awaddr), 0);
                end else begin
                    ea = exp_addr.pop_front();
                    chk(m_awaddr == ea, "awaddr", 64'(m_awaddr), 64'(ea));
                end
                chk(m_awlen == 8'(BL - 1), "awlen", 64'(m_awlen), 64'(BL - 1));
                mon_beats = 0;
                mon_reads = 0;
            end
            if (m_wvalid && m_wready) begin
                if (exp_data.size() == 0) begin
                    chk(0, "w_unexpected", m_wdata, 0);
                end else begin
                    ed = exp_data.pop_front();
                    chk(m_wdata == ed, "wdata", m_wdata, ed);
                end
                if (mon_beats == 0) first_cyc = mcyc;
                chk(m_wlast == (mon_beats == BL - 1), "wlast", 64'(m_wlast), 64'(mon_beats == BL - 1));
                if (m_wlast) begin
                    chk(mon_reads == BL, "reads_per_burst", 64'(mon_reads), 64'(BL));
                    if (full_rate)
                        chk(mcyc - first_cyc == BL - 1, "throughput", 64'(mcyc - first_cyc), 64'(BL - 1));
                end
                mon_beats++;
            end
            if (m_bvalid && m_bready) begin
                if (exp_fd.size() == 0) chk(0, "b_unexpected", 1, 0);
                else fd_next = exp_fd.pop_front();
                busy_low = 1;
                bursts_done++;
            end
            prev_aw_stall = m_awvalid && !m_awready;
            prev_awaddr   = m_awaddr;
            prev_w_stall  = m_wvalid && !m_wready;
            prev_wdata    = m_wdata;
        end
    end

    initial begin
        bit seen;
        int start;
        rst = 1; frame_start = 0; fifo_rd_data = '0; fifo_rd_empty = 1;
        fifo_rd_water_level = '0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        step();
        step();
        check_idle_outputs();
        rst = 0;
        step();

        // Single burst, all ready, known pattern, full-rate streaming
        full_rate = 1;
        burst(1);
        full_rate = 0;

        // Water level one short of a burst must not start anything
        feed_words(BL - 1, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk(!m_awvalid && !fifo_rd_en, "level15_idle", 64'({m_awvalid, fifo_rd_en}), 0);
        end
        start = bursts_done;
        feed_words(1, 0);
        expect_burst();
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin
            step();
            seen = m_awvalid;
        end
        chk(seen, "aw_latency", 64'(seen), 1);
        wait_done(start);

        // Random backpressure over a full frame, then wrap to BASE
        aw_pct = 50; w_pct = 50; b_pct = 50;
        pulse_fs();
        for (int b = 0; b < 5; b++) burst(0);

        // frame_start during DATA of a burst only affects the next one
        pulse_fs();
        burst(0);
        start = bursts_done;
        feed_words(BL, 0);
        expect_burst();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            seen = m_wvalid;
        end
        chk(seen, "reach_data", 64'(seen), 1);
        fs_req = 1;
        model_off = 0;
        wait_done(start);
        burst(0);

        // frame_start in the same cycle as the response handshake
        aw_pct = 100; w_pct = 100; b_pct = 100;
        b_manual = 1; b_force = 0;
        start = bursts_done;
        feed_words(BL, 0);
        expect_burst();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            seen = m_bready;
        end
        chk(seen, "reach_resp", 64'(seen), 1);
        b_force = 1;
        fs_req = 1;
        model_off = 0;
        step();
        b_force = 0;
        b_manual = 0;
        wait_done(start);
        burst(0);

        // Reset five beats into a burst
        feed_words(BL, 0);
        expect_burst();
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step();
            seen = (mon_beats >= 5);
        end
        chk(seen, "reach_beat5", 64'(mon_beats), 5);
        rst = 1;
        step();
        check_idle_outputs();
        fifo_q.delete();
        exp_data.delete();
        exp_addr.delete();
        exp_fd.delete();
        rd_pend = 0;
        model_off = 0;
        rst = 0;
        step();
        burst(1);

        for (int i = 0; i < 5; i++) step();
        chk(exp_data.size() == 0 && exp_addr.size() == 0, "scoreboard_drained",
            64'(exp_data.size() + exp_addr.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
